carry_pulse_sched: RTL and testbench

CARRY_PULSE_SCHED -- requirements
Module: carry_pulse_sched

---
 rtl/carry_pulse_sched.sv | 145 ++++++++++++++
 tb/tb_carry_pulse_sched.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/carry_pulse_sched.sv
// Round-robin scheduler sharing one down-counter among NREQ requesters; emits a
// registered carry/done pulse at terminal count. Define CARRY_PULSE_SCHED_CNT_EN to enable the carry tally.
module carry_pulse_sched #(
    parameter int NREQ = 4,
    parameter int CW   = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] len,
    output logic [NREQ-1:0]    grant,
    output logic               busy,
    output logic               carry,
    output logic [NREQ-1:0]    done,
    output logic [CW-1:0]      cur_cnt,
    output logic [15:0]        carry_cnt,
    output logic [1:0]         dbg_state
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Handshake: req is a level sampled only in IDLE; once accepted, grant holds
    // from the next cycle through the DONE cycle regardless of req or len.
    logic [1:0]      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            carry_q, carry_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            sel_valid;
    logic [PW-1:0]   sel_idx;
    logic [CW-1:0]   sel_len;
    int              rr_idx;

    // Scan offsets from high to low so the closest set bit at/after ptr wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        rr_idx    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            rr_idx = int'(ptr_q) + k;
            if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
            if (req[rr_idx]) begin
                sel_valid = 1'b1;
                sel_idx   = PW'(rr_idx);
            end
        end
    end

    assign sel_len = len[int'(sel_idx)*CW +: CW];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        carry_d = 1'b0;
        done_d  = '0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                if (sel_valid) begin
                    state_d = ST_COUNT;
                    grant_d = NREQ'(1) << sel_idx;
                    busy_d  = 1'b1;
                    cnt_d   = (sel_len == '0) ? CW'(1) : sel_len;
                    ptr_d   = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
                end
            end
            ST_COUNT: begin
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    carry_d = 1'b1;
                    done_d  = grant_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            carry_q <= 1'b0;
            done_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef CARRY_PULSE_SCHED_CNT_EN
    logic [15:0] carry_cnt_q, carry_cnt_d;

    always_comb carry_cnt_d = carry_cnt_q + {15'd0, carry_d};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) carry_cnt_q <= '0;
        else         carry_cnt_q <= carry_cnt_d;
    end

    assign carry_cnt = carry_cnt_q;
`else
    assign carry_cnt = 16'd0;
`endif

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign carry     = carry_q;
    assign done      = done_q;
    assign cur_cnt   = cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_carry_pulse_sched.sv
// Bench for carry_pulse_sched: transaction-level schedule model plus a concurrent
// carry-spacing / done-vs-grant checker; honours CARRY_PULSE_SCHED_CNT_EN.
module tb_carry_pulse_sched;
  localparam int NREQ = 4;
  localparam int CW   = 16;
`ifdef CARRY_PULSE_SCHED_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*CW-1:0] len = '0;
  logic [NREQ-1:0]    grant;
  logic               busy;
  logic               carry;
  logic [NREQ-1:0]    done;
  logic [CW-1:0]      cur_cnt;
  logic [15:0]        carry_cnt;
  logic [1:0]         dbg_state;

  int total = 0;
  int bad   = 0;

  carry_pulse_sched #(.NREQ(NREQ), .CW(CW)) dut (
    .clk(clk), .resetn(resetn), .req(req), .len(len),
    .grant(grant), .busy(busy), .carry(carry), .done(done),
    .cur_cnt(cur_cnt), .carry_cnt(carry_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // One expected output set per cycle.
  typedef struct packed {
    logic [NREQ-1:0] grant;
    logic            busy;
    logic            carry;
    logic [NREQ-1:0] done;
    logic [CW-1:0]   cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          m_ptr = 0;
  logic [15:0] m_carries = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge: check this cycle's outputs, then drive inputs sampled at the next posedge.
  task automatic cycle(input logic [NREQ-1:0] r, input logic [NREQ*CW-1:0] l);
    exp_t e;
    bit   idle;
    int   sel;
    int   ln;
    if (exp_q.size() == 0) begin
      idle = 1'b1;
      e = '0;
    end else begin
      idle = 1'b0;
      e = exp_q.pop_front();
    end
    check("grant", 32'(grant), 32'(e.grant));
    check("busy", 32'(busy), 32'(e.busy));
    check("carry", 32'(carry), 32'(e.carry));
    check("done", 32'(done), 32'(e.done));
    check("cur_cnt", 32'(cur_cnt), 32'(e.cnt));
    if (e.carry) m_carries = m_carries + 16'd1;
    if (idle) check("carry_cnt", 32'(carry_cnt), CNT_EN ? 32'(m_carries) : 32'd0);
    req = r;
    len = l;
    if (idle && r != '0) begin
      sel = -1;
      for (int k = 0; k < NREQ; k++)
        if (sel < 0 && r[(m_ptr + k) % NREQ]) sel = (m_ptr + k) % NREQ;
      ln = int'(l[sel*CW +: CW]);
      if (ln == 0) ln = 1;
      for (int k = 0; k < ln; k++) begin
        e.grant = NREQ'(1 << sel); e.busy = 1'b1; e.carry = 1'b0;
        e.done = '0; e.cnt = CW'(ln - k);
        exp_q.push_back(e);
      end
      e.grant = NREQ'(1 << sel); e.busy = 1'b1; e.carry = 1'b1;
      e.done = NREQ'(1 << sel); e.cnt = '0;
      exp_q.push_back(e);
      m_ptr = (sel + 1) % NREQ;
    end
    @(negedge clk);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      cycle('0, '0);
      n++;
    end
    check("drain_bound", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Asynchronous reset mid-cycle, held with all requests raised.
  task automatic do_reset();
    #2 resetn = 1'b0;
    req = '1;
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cnt", 32'(cur_cnt), 32'd0);
    check("rst_carry_cnt", 32'(carry_cnt), 32'd0);
    exp_q.delete();
    m_ptr = 0;
    m_carries = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_hold_carry", 32'(carry), 32'd0);
      check("rst_hold_grant", 32'(grant), 32'd0);
    end
    resetn = 1'b1;
    req = '0;
  endtask

  function automatic logic [NREQ*CW-1:0] rand_lens();
    logic [NREQ*CW-1:0] v;
    for (int i = 0; i < NREQ; i++)
      v[i*CW +: CW] = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 20))
                                                   : CW'($urandom_range(0, 3));
    return v;
  endfunction

  // Concurrent carry-spacing and done-vs-grant checker.
  logic            prev_carry = 1'b0;
  logic [NREQ-1:0] prev_grant = '0;
  int              gap = 100;
  always @(negedge clk) begin
    if (!resetn) begin
      prev_carry = 1'b0;
      prev_grant = '0;
      gap = 100;
    end else begin
      if (carry) begin
        check("prop_no_back2back", 32'(prev_carry), 32'd0);
        check("prop_gap_ge2", 32'(gap >= 2), 32'd1);
        check("prop_done_prev_grant", 32'(done), 32'(prev_grant));
        gap = 0;
      end else if (gap < 100) begin
        gap++;
      end
      prev_carry = carry;
      prev_grant = grant;
    end
  end

  initial begin
    logic [NREQ*CW-1:0] l;
    // Power-on reset
    #1;
    check("por_grant", 32'(grant), 32'd0);
    check("por_busy", 32'(busy), 32'd0);
    check("por_cnt", 32'(cur_cnt), 32'd0);
    check("por_carry_cnt", 32'(carry_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Single requester, len=3
    l = '0; l[0 +: CW] = 16'd3;
    cycle(4'b0001, l);
    cycle(4'b0000, '0);
    check("d_cnt3", 32'(cur_cnt), 32'd2);
    drain(20);
    cycle(4'b0000, '0);

    // All requesting, len=1, fresh pointer: order 0,1,2,3,0
    do_reset();
    l = '0;
    for (int i = 0; i < NREQ; i++) l[i*CW +: CW] = 16'd1;
    for (int i = 0; i < 15; i++) cycle(4'b1111, l);
    drain(20);

    // len=0 behaves as len=1
    l = '0;
    cycle(4'b0100, l);
    check("len0_grant", 32'(grant), 32'b0100);
    cycle(4'b0000, l);
    check("len0_carry", 32'(carry), 32'd1);
    drain(20);

    // Reset mid-COUNT of len=10, then all request: requester 0 first
    l = '0; l[0 +: CW] = 16'd10;
    cycle(4'b0001, l);
    for (int i = 0; i < 4; i++) cycle(4'b0000, l);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(4'b0000, '0);
    l = '0;
    for (int i = 0; i < NREQ; i++) l[i*CW +: CW] = 16'd2;
    cycle(4'b1111, l);
    check("post_rst_grant0", 32'(grant), 32'b0001);
    drain(20);

    // Five completed operations
    do_reset();
    for (int n = 0; n < 5; n++) begin
      cycle(NREQ'(1 << (n % NREQ)), rand_lens());
      drain(40);
    end
    cycle(4'b0000, '0);
    check("carry_cnt5", 32'(carry_cnt), CNT_EN ? 32'd5 : 32'd0);

    // Random traffic with occasional resets
    for (int i = 0; i < 10000; i++) begin
      if (i % 2500 == 1234) do_reset();
      cycle(($urandom_range(0, 4) == 0) ? 4'b0000 : NREQ'($urandom_range(0, 15)), rand_lens());
    end
    drain(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
